cpu_stat_unit: RTL and testbench
================================

# cpu_stat_unit

Parametrised run-control and statistics block for the single-cycle MIPS CPU top: it owns the halt-on-syscall / resume-on-Go state machine that gates the PC enable, and counts retired instructions plus NUM_EV qualified event classes (branch taken, jump, etc.). It generalises the fixed three-counter scheme to N channels, with selectable wrap/saturate arithmetic, sticky overflow, an atomic snapshot, and a registered readback port.

## Interface
- NUM_EV, 2: number of event channels; counter 0 is retired instructions, counters 1..NUM_EV are events.
- CNT_W, 32: counter width in bits.
- SAT, 0: 0 = wrap to zero on overflow, 1 = hold at all-ones.
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  reset, synchronous, active-low.
- retire  in  1  an instruction completes this cycle.
- ev  in  NUM_EV  event flags; ev[i] is qualified by retire.
- halt_req  in  1  the retiring instruction is a halting syscall.
- go  in  1  resume button, level; only its rising edge acts.
- clear_cnt  in  1  pulse: zero all live counters and overflow flags.
- snap  in  1  pulse: copy all live counters into shadow registers.
- sel  in  SEL_W = $clog2(NUM_EV+1)  readback channel select.
- rd_shadow  in  1  1 = read shadow copy, 0 = read live counter.
- run  out  1  PC enable; 1 in RUN state.
- rd_data  out  CNT_W  registered readback value.
- ovf  out  NUM_EV+1  sticky overflow flag per counter.

## Operation
- States: RUN, HALTED. Reset state RUN.
- RUN -> HALTED when retire & halt_req. The halting instruction is counted.
- HALTED -> RUN when go rising edge (go=1 this cycle, go_q=0); go_q is go registered, reset 0.
- go edge in RUN: ignored. go held high across a halt does not resume; a new edge is required.
- Increment enable: inc[0] = run & retire; inc[i] = run & retire & ev[i-1]. retire while HALTED is ignored.
- Counter arithmetic, CNT_W bits unsigned: on inc, if value = all-ones then ovf[i] <= 1 and value <= 0 (SAT=0) or stays all-ones (SAT=1); otherwise value+1.
- clear_cnt: all live counters <= 0, all ovf <= 0; wins over simultaneous inc (result 0, ovf 0). Shadows untouched.
- snap: shadow[i] <= live[i] as of before this edge (pre-increment, pre-clear). snap with clear_cnt: shadow gets old values, live becomes 0.
- Readback: rd_data <= (rd_shadow ? shadow[sel] : live[sel]); sel > NUM_EV yields 0.
- Reset (clr=0 at an edge): state RUN, run=1, all live/shadow counters 0, ovf 0, rd_data 0, go_q 0. Reset mid-halt returns to RUN; reset dominates every other input.

## Timing
- run changes the edge after the triggering condition; an instruction retiring with halt_req is the last retired until resume.
- Counters reflect an inc in the cycle after it is asserted.
- rd_data latency 1 cycle from sel/rd_shadow; live readback shows value after that edge's prior updates (pre-this-cycle increment).
- go edge at cycle t -> run=1 at t+1 -> first counted retire at t+1.
- No handshake; all pulses are single-cycle and sampled every edge.

## Structure
- Package cpu_stat_pkg: state enum (ST_RUN, ST_HALTED), SAT_WRAP=0 / SAT_HOLD=1 constants, SEL_W helper function.
- Sub-module stat_counter (CNT_W, SAT): one live counter, its shadow, and sticky ovf; ports clk, clr, inc, clear, snap, value, shadow, ovf. Instantiated NUM_EV+1 times via generate.
- Top holds FSM, go edge detector, inc decode and readback mux.

## Test plan
- Reset then 5 cycles retire=1, ev=2'b01 -> live0=5, live1=5, live2=0, run=1, ovf=0.
- retire=1, halt_req=1 at live0=5 -> live0=6, run=0 next cycle; 3 more retires -> live0 stays 6; go 0->1 -> run=1 one cycle later; go held high through a second halt -> stays halted until go drops and rises.
- CNT_W=4, SAT=0: 16 increments on counter 0 -> value 0, ovf[0]=1; SAT=1: value 15, ovf[0]=1; clear_cnt -> 0, ovf 0.
- live0=7 with inc, snap and clear_cnt in same cycle -> shadow0=7, live0=0, ovf=0.
- sel=1, rd_shadow=0 -> rd_data=live1 next cycle; sel=3 with NUM_EV=2 -> rd_data=0.
- clr=0 asserted while HALTED with nonzero counters -> next cycle run=1, all counters, shadows, ovf, rd_data = 0.

Source files
------------

// File: rtl/cpu_stat_pkg.sv
// Shared types and constants for the CPU run-control and statistics block.
// Imported by the counter channel and the top.
package cpu_stat_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_t;

  localparam int SAT_WRAP = 0;
  localparam int SAT_HOLD = 1;

  function automatic int sel_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/stat_counter.sv
// One statistics channel: live counter, snapshot shadow and sticky overflow.
// Clear beats increment; snapshot always captures the pre-edge value.
module stat_counter
  import cpu_stat_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int SAT   = SAT_WRAP
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  input  logic             clear,
  input  logic             snap,
  output logic [CNT_W-1:0] value,
  output logic [CNT_W-1:0] shadow,
  output logic             ovf
);

  always_ff @(posedge clk) begin
    if (!clr) begin
      value  <= '0;
      shadow <= '0;
      ovf    <= 1'b0;
    end else begin
      if (snap) shadow <= value;
      if (clear) begin
        value <= '0;
        ovf   <= 1'b0;
      end else if (inc) begin
        if (&value) begin
          ovf   <= 1'b1;
          value <= (SAT == SAT_HOLD) ? value : '0;
        end else begin
          value <= value + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/cpu_stat_unit.sv
// Halt/resume run control plus retired-instruction and event counters
// with snapshot shadows and a registered readback port.
module cpu_stat_unit
  import cpu_stat_pkg::*;
#(
  parameter  int NUM_EV = 2,
  parameter  int CNT_W  = 32,
  parameter  int SAT    = SAT_WRAP,
  localparam int SEL_W  = sel_w(NUM_EV + 1)
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              retire,
  input  logic [NUM_EV-1:0] ev,
  input  logic              halt_req,
  input  logic              go,
  input  logic              clear_cnt,
  input  logic              snap,
  input  logic [SEL_W-1:0]  sel,
  input  logic              rd_shadow,
  output logic              run,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_EV:0]   ovf
);

  state_t state, state_nxt;
  logic   go_q;
  logic   go_rise;

  logic [NUM_EV:0]    inc;
  logic [CNT_W-1:0]   live [NUM_EV+1];
  logic [CNT_W-1:0]   shad [NUM_EV+1];
  logic [CNT_W-1:0]   rd_nxt;

  assign go_rise = go & ~go_q;

  always_ff @(posedge clk) begin
    if (!clr) begin
      state <= ST_RUN;
      go_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      go_q  <= go;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_RUN:    if (retire && halt_req) state_nxt = ST_HALTED;
      ST_HALTED: if (go_rise)            state_nxt = ST_RUN;
      default:                           state_nxt = ST_RUN;
    endcase
  end

  always_comb begin
    run = (state == ST_RUN);
  end

  always_comb begin
    inc[0] = run & retire;
    for (int i = 1; i <= NUM_EV; i++) begin
      inc[i] = run & retire & ev[i-1];
    end
  end

  for (genvar g = 0; g <= NUM_EV; g++) begin : g_ch
    stat_counter #(
      .CNT_W (CNT_W),
      .SAT   (SAT)
    ) u_cnt (
      .clk    (clk),
      .clr    (clr),
      .inc    (inc[g]),
      .clear  (clear_cnt),
      .snap   (snap),
      .value  (live[g]),
      .shadow (shad[g]),
      .ovf    (ovf[g])
    );
  end

  // Out-of-range selects fall through to zero.
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i <= NUM_EV; i++) begin
      if (sel == SEL_W'(i)) begin
        rd_nxt = rd_shadow ? shad[i] : live[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!clr) rd_data <= '0;
    else      rd_data <= rd_nxt;
  end

endmodule

// File: tb/tb_cpu_stat_unit.sv
// Randomised scoreboard bench: wrap and saturate instances share stimulus
// and are compared every cycle against a counting reference model.
module tb_cpu_stat_unit;

  localparam int NEV = 2;
  localparam int CW  = 4;
  localparam int MX  = (1 << CW) - 1;

  logic           clk = 1'b0;
  logic           clr, retire, halt_req, go, clear_cnt, snap, rd_shadow;
  logic [NEV-1:0] ev;
  logic [1:0]     sel;
  logic           run_w, run_h;
  logic [CW-1:0]  rd_w, rd_h;
  logic [NEV:0]   ovf_w, ovf_h;

  always #5 clk = ~clk;

  cpu_stat_unit #(.NUM_EV(NEV), .CNT_W(CW), .SAT(0)) u_wrap (
    .clk(clk), .clr(clr), .retire(retire), .ev(ev),
    .halt_req(halt_req), .go(go), .clear_cnt(clear_cnt),
    .snap(snap), .sel(sel), .rd_shadow(rd_shadow),
    .run(run_w), .rd_data(rd_w), .ovf(ovf_w)
  );

  cpu_stat_unit #(.NUM_EV(NEV), .CNT_W(CW), .SAT(1)) u_hold (
    .clk(clk), .clr(clr), .retire(retire), .ev(ev),
    .halt_req(halt_req), .go(go), .clear_cnt(clear_cnt),
    .snap(snap), .sel(sel), .rd_shadow(rd_shadow),
    .run(run_h), .rd_data(rd_h), .ovf(ovf_h)
  );

  typedef struct {
    bit       run;
    int       rd   [2];
    bit [2:0] ovf  [2];
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference state: index m=0 wrap, m=1 saturate.
  int       live [2][3];
  int       sh   [2][3];
  bit [2:0] m_ovf[2];
  bit       m_halt;
  bit       m_goq;

  task automatic tick();
    exp_t e;
    bit   running;
    running = !m_halt;
    for (int m = 0; m < 2; m++) begin
      if (!clr) begin
        for (int i = 0; i < 3; i++) begin
          live[m][i] = 0;
          sh[m][i]   = 0;
        end
        m_ovf[m] = '0;
        e.rd[m]  = 0;
      end else begin
        if (sel > 2) e.rd[m] = 0;
        else e.rd[m] = rd_shadow ? sh[m][sel] : live[m][sel];
        if (snap)
          for (int i = 0; i < 3; i++) sh[m][i] = live[m][i];
        for (int i = 0; i < 3; i++) begin
          if (clear_cnt) begin
            live[m][i] = 0;
            m_ovf[m][i] = 1'b0;
          end else if (running && retire && (i == 0 || ev[i-1])) begin
            if (live[m][i] == MX) begin
              m_ovf[m][i] = 1'b1;
              live[m][i] = (m == 1) ? MX : 0;
            end else begin
              live[m][i]++;
            end
          end
        end
      end
      e.ovf[m] = m_ovf[m];
    end
    if (!clr) begin
      m_halt = 0;
      m_goq  = 0;
    end else begin
      if (m_halt && go && !m_goq) m_halt = 0;
      else if (!m_halt && retire && halt_req) m_halt = 1;
      m_goq = go;
    end
    e.run = !m_halt;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("run_wrap", int'(run_w), int'(e.run));
        chk("run_hold", int'(run_h), int'(e.run));
        chk("rd_wrap",  int'(rd_w),  e.rd[0]);
        chk("rd_hold",  int'(rd_h),  e.rd[1]);
        chk("ovf_wrap", int'(ovf_w), int'(e.ovf[0]));
        chk("ovf_hold", int'(ovf_h), int'(e.ovf[1]));
      end
    end
  end

  task automatic idle();
    clr = 1; retire = 0; ev = '0; halt_req = 0; go = 0;
    clear_cnt = 0; snap = 0; sel = '0; rd_shadow = 0;
  endtask

  initial begin : stim
    idle();
    clr = 0;
    @(negedge clk);
    tick(); tick();
    clr = 1;
    retire = 1; ev = 2'b01;
    for (int i = 0; i < 5; i++) begin sel = 2'(i % 3); tick(); end
    retire = 0;
    for (int i = 0; i < 3; i++) begin sel = 2'(i); tick(); end
    retire = 1; halt_req = 1; tick();
    halt_req = 0;
    for (int i = 0; i < 3; i++) begin sel = 0; tick(); end
    go = 1; tick();
    halt_req = 1; tick();
    halt_req = 0;
    for (int i = 0; i < 3; i++) tick();
    go = 0; tick();
    go = 1; tick();
    go = 0; ev = 2'b11;
    for (int i = 0; i < 20; i++) begin sel = 2'(i % 3); tick(); end
    retire = 0; sel = 0; tick();
    clear_cnt = 1; tick();
    clear_cnt = 0; retire = 1;
    for (int i = 0; i < 7; i++) tick();
    snap = 1; clear_cnt = 1; tick();
    snap = 0; clear_cnt = 0; retire = 0;
    rd_shadow = 1; sel = 0; tick();
    rd_shadow = 0; tick();
    sel = 1; tick();
    sel = 3; tick(); tick();
    retire = 1; ev = 2'b10; tick(); tick();
    halt_req = 1; tick();
    halt_req = 0; clr = 0; tick();
    clr = 1; retire = 0; tick();
    for (int n = 0; n < 3000; n++) begin
      clr       = ($urandom % 250) != 0;
      retire    = ($urandom % 4) != 0;
      ev        = 2'($urandom);
      halt_req  = ($urandom % 16) == 0;
      go        = ($urandom % 6) == 0;
      clear_cnt = ($urandom % 60) == 0;
      snap      = ($urandom % 8) == 0;
      sel       = 2'($urandom);
      rd_shadow = 1'($urandom);
      tick();
    end
    idle();
    tick();
    #2;
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
